// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, arbiter FSM states and widths
package alu_pkg;

  localparam int ALU_NUM_BITS = 16;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0001;
  localparam logic [3:0] ID   = 4'b0010;
  localparam logic [3:0] NOT  = 4'b0011;
  localparam logic [3:0] AND  = 4'b0100;
  localparam logic [3:0] OR   = 4'b0101;
  localparam logic [3:0] NAND = 4'b0110;
  localparam logic [3:0] NOR  = 4'b0111;
  localparam logic [3:0] XOR  = 4'b1000;
  localparam logic [3:0] XNOR = 4'b1001;
  localparam logic [3:0] LLS  = 4'b1010;
  localparam logic [3:0] LRS  = 4'b1011;
  localparam logic [3:0] ALS  = 4'b1100;
  localparam logic [3:0] ARS  = 4'b1101;
  localparam logic [3:0] TCP  = 4'b1110;
  localparam logic [3:0] ZERO = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; overflow flag only meaningful for ADD/SUB
module alu
  import alu_pkg::*;
#(
  parameter int NUM_BITS = ALU_NUM_BITS
) (
  input  logic [NUM_BITS-1:0] i_a,
  input  logic [NUM_BITS-1:0] i_b,
  input  logic [3:0]          i_func,
  output logic [NUM_BITS-1:0] o_c,
  output logic                o_ovf
);

  localparam int M = NUM_BITS - 1;

  logic [NUM_BITS-1:0] w_sum;
  logic [NUM_BITS-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  // operation select; shifts are by one position
  always_comb begin
    o_c   = '0;
    o_ovf = 1'b0;
    case (i_func)
      ADD: begin
        o_c   = w_sum;
        o_ovf = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
      end
      SUB: begin
        o_c   = w_diff;
        o_ovf = (i_a[M] != i_b[M]) && (w_diff[M] != i_a[M]);
      end
      ID:      o_c = i_a;
      NOT:     o_c = ~i_a;
      AND:     o_c = i_a & i_b;
      OR:      o_c = i_a | i_b;
      NAND:    o_c = ~(i_a & i_b);
      NOR:     o_c = ~(i_a | i_b);
      XOR:     o_c = i_a ^ i_b;
      XNOR:    o_c = ~(i_a ^ i_b);
      LLS:     o_c = {i_a[M-1:0], 1'b0};
      LRS:     o_c = {1'b0, i_a[M:1]};
      ALS:     o_c = {i_a[M-1:0], 1'b0};
      ARS:     o_c = {i_a[M], i_a[M:1]};
      TCP:     o_c = (~i_a) + NUM_BITS'(1);
      default: o_c = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick favouring the port not granted last
module rr_pick2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_sel,
  output logic o_any
);

  // a lone requester wins outright; a tie goes to the port not served last
  always_comb begin
    o_any = i_valid0 | i_valid1;
    o_sel = (i_valid0 && i_valid1) ? ~i_last_grant : i_valid1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin front end for one shared registered ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_BITS = ALU_NUM_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [NUM_BITS-1:0] req0_a,
  input  logic [NUM_BITS-1:0] req0_b,
  input  logic [3:0]          req0_func,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [NUM_BITS-1:0] req1_a,
  input  logic [NUM_BITS-1:0] req1_b,
  input  logic [3:0]          req1_func,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [NUM_BITS-1:0] rsp0_c,
  output logic                rsp0_ovf,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [NUM_BITS-1:0] rsp1_c,
  output logic                rsp1_ovf,
  output logic                busy,
  output logic [CNT_BITS-1:0] ops_done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_gnt;
  logic [NUM_BITS-1:0] r_op_a;
  logic [NUM_BITS-1:0] r_op_b;
  logic [3:0]          r_op_func;
  logic [NUM_BITS-1:0] r_res_c;
  logic                r_res_ovf;
  logic [CNT_BITS-1:0] r_ops_done;

  logic                w_sel;
  logic                w_any;
  logic                w_accept;
  logic                w_rsp_hs;
  logic [NUM_BITS-1:0] w_alu_c;
  logic                w_alu_ovf;

  rr_pick2 u_pick (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_sel        (w_sel),
    .o_any        (w_any)
  );

  alu #(.NUM_BITS(NUM_BITS)) u_alu (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_func (r_op_func),
    .o_c    (w_alu_c),
    .o_ovf  (w_alu_ovf)
  );

  assign w_accept = (r_state == IDLE) && w_any;
  assign w_rsp_hs = (r_state == RESP) && (r_gnt ? rsp1_ready : rsp0_ready);
  assign ops_done = r_ops_done;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state: accept in IDLE, one EXEC cycle, hold RESP until the consumer takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // outputs: ready gated by reset_n so every output is low while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp0_c     = '0;
    rsp0_ovf   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_c     = '0;
    rsp1_ovf   = 1'b0;
    busy       = (r_state != IDLE);
    if (r_state == IDLE && reset_n) begin
      req0_ready = req0_valid && !w_sel;
      req1_ready = req1_valid && w_sel;
    end
    if (r_state == RESP) begin
      if (r_gnt) begin
        rsp1_valid = 1'b1;
        rsp1_c     = r_res_c;
        rsp1_ovf   = r_res_ovf;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_c     = r_res_c;
        rsp0_ovf   = r_res_ovf;
      end
    end
  end

  // operand capture, result capture, grant history and saturating op counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_func    <= '0;
      r_res_c      <= '0;
      r_res_ovf    <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gnt     <= w_sel;
            r_op_a    <= w_sel ? req1_a : req0_a;
            r_op_b    <= w_sel ? req1_b : req0_b;
            r_op_func <= w_sel ? req1_func : req0_func;
          end
        end
        EXEC: begin
          r_res_c   <= w_alu_c;
          r_res_ovf <= w_alu_ovf;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_last_grant <= r_gnt;
            if (r_ops_done != '1) r_ops_done <= r_ops_done + CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_func, req1_func;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_c, rsp1_c;
  logic        rsp0_ovf, rsp1_ovf, busy;
  logic [15:0] ops_done;

  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
  logic [15:0] s_rsp0_c, s_rsp1_c;
  logic        s_rsp0_ovf, s_rsp1_ovf, s_busy;
  logic [1:0]  s_ops_done;

  int n_total = 0;
  int n_pass  = 0;
  int exp_ops = 0;

  alu_arbiter #(.NUM_BITS(16), .CNT_BITS(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_ovf(rsp1_ovf),
    .busy(busy), .ops_done(ops_done)
  );

  alu_arbiter #(.NUM_BITS(16), .CNT_BITS(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(s_rsp0_c), .rsp0_ovf(s_rsp0_ovf),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(s_rsp1_c), .rsp1_ovf(s_rsp1_ovf),
    .busy(s_busy), .ops_done(s_ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    int          port;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] c;
    logic        ovf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  int   grants[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic get_rsp_valid(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [15:0] get_rsp_c(input int p);
    return (p == 0) ? rsp0_c : rsp1_c;
  endfunction

  function automatic logic get_rsp_ovf(input int p);
    return (p == 0) ? rsp0_ovf : rsp1_ovf;
  endfunction

  task automatic set_valid(input int p, input logic v);
    if (p == 0) req0_valid = v;
    else        req1_valid = v;
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  task automatic drive_req(input int p, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    if (p == 0) begin
      req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1;
    end
  endtask

  task automatic check_ops(input string tag);
    check({tag, "_ops_done"}, ops_done, exp_ops);
    check({tag, "_ops_sat"}, s_ops_done, (exp_ops > 3) ? 3 : exp_ops);
  endtask

  // polls (from a negedge) until port p is readied; caller then waits for the accept edge
  task automatic wait_ready(input int p, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (get_ready(p)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ready_seen"}, got, 1'b1);
  endtask

  // called right after the accept edge: checks EXEC, RESP contents, hold, handshake
  task automatic finish_rsp(input int p, input logic [15:0] ec, input logic eo, input int hold, input string tag);
    @(negedge clk);
    #1;
    check({tag, "_ready_one_cycle"}, get_ready(p), 1'b0);
    check({tag, "_exec_busy"}, busy, 1'b1);
    check({tag, "_exec_no_rsp"}, get_rsp_valid(p), 1'b0);
    set_valid(p, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"}, get_rsp_valid(p), 1'b1);
    check({tag, "_rsp_c"}, get_rsp_c(p), ec);
    check({tag, "_rsp_ovf"}, get_rsp_ovf(p), eo);
    check({tag, "_other_valid"}, get_rsp_valid(1 - p), 1'b0);
    check({tag, "_other_c"}, get_rsp_c(1 - p), 16'h0000);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check({tag, "_hold_valid"}, get_rsp_valid(p), 1'b1);
      check({tag, "_hold_c"}, get_rsp_c(p), ec);
    end
    set_rsp_ready(p, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp_ready(p, 1'b0);
    exp_ops++;
    #1;
    check({tag, "_rsp_dropped"}, get_rsp_valid(p), 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check_ops(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_ops = 0;
  endtask

  initial begin
    vecs[0]  = '{0, 16'h7FFF, 16'h0001, ADD,  16'h8000, 1'b1};
    vecs[1]  = '{1, 16'h0005, 16'h0003, SUB,  16'h0002, 1'b0};
    vecs[2]  = '{0, 16'hFFFF, 16'h0001, ADD,  16'h0000, 1'b0};
    vecs[3]  = '{1, 16'h8000, 16'h8000, ADD,  16'h0000, 1'b1};
    vecs[4]  = '{0, 16'h7FFF, 16'hFFFF, SUB,  16'h8000, 1'b1};
    vecs[5]  = '{1, 16'h1234, 16'h5555, ID,   16'h1234, 1'b0};
    vecs[6]  = '{0, 16'h00FF, 16'h0000, NOT,  16'hFF00, 1'b0};
    vecs[7]  = '{1, 16'hF0F0, 16'h3C3C, AND,  16'h3030, 1'b0};
    vecs[8]  = '{0, 16'hF0F0, 16'h0F00, OR,   16'hFFF0, 1'b0};
    vecs[9]  = '{1, 16'h00F0, 16'h0F00, NOR,  16'hF00F, 1'b0};
    vecs[10] = '{0, 16'h1234, 16'h1234, XNOR, 16'hFFFF, 1'b0};
    vecs[11] = '{1, 16'h8001, 16'h0000, LLS,  16'h0002, 1'b0};
    vecs[12] = '{0, 16'h8001, 16'h0000, LRS,  16'h4000, 1'b0};
    vecs[13] = '{1, 16'h4001, 16'h0000, ALS,  16'h8002, 1'b0};
    vecs[14] = '{0, 16'h0001, 16'h0000, TCP,  16'hFFFF, 1'b0};
    vecs[15] = '{1, 16'hFFFF, 16'hFFFF, ZERO, 16'h0000, 1'b0};
    vecs[16] = '{0, 16'h8004, 16'h0000, ARS,  16'hC002, 1'b0};
    vecs[17] = '{1, 16'h4004, 16'h0000, ARS,  16'h2002, 1'b0};

    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_func = '0;
    req1_a = '0; req1_b = '0; req1_func = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_rsp0_c", rsp0_c, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check_ops("rst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // single-requester vectors across all function codes
    for (int i = 0; i < NV; i++) begin
      drive_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].f);
      wait_ready(vecs[i].port, $sformatf("v%0d", i));
      @(posedge clk);
      finish_rsp(vecs[i].port, vecs[i].c, vecs[i].ovf, (i == 3) ? 2 : 0, $sformatf("v%0d", i));
    end

    // both valid right after reset: port 0 first, then port 1
    do_reset();
    drive_req(0, 16'h8000, 16'h0001, SUB);
    drive_req(1, 16'h8004, 16'h0000, ARS);
    #1;
    check("t2_req0_ready", req0_ready, 1'b1);
    check("t2_req1_not_ready", req1_ready, 1'b0);
    @(posedge clk);
    finish_rsp(0, 16'h7FFF, 1'b1, 0, "t2p0");
    wait_ready(1, "t2p1");
    @(posedge clk);
    finish_rsp(1, 16'hC002, 1'b0, 0, "t2p1");

    // continuous contention: grants must alternate
    for (int i = 0; i < 6; i++) grants[i] = -1;
    begin
      int ng;
      ng = 0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      drive_req(0, 16'h1234, 16'h1111, ADD);
      drive_req(1, 16'hFF00, 16'h0F0F, XOR);
      for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
        #1;
        if (req0_ready) begin grants[ng] = 0; ng = ng + 1; end
        else if (req1_ready) begin grants[ng] = 1; ng = ng + 1; end
        if (rsp0_valid) check("t3_rsp0_c", rsp0_c, 16'h2345);
        if (rsp1_valid) check("t3_rsp1_c", rsp1_c, 16'hF00F);
        if (ng < 6) @(negedge clk);
      end
      check("t3_grant_count", ng, 6);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      exp_ops += 6;
      #1;
      for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), grants[i], i % 2);
      check("t3_idle", busy, 1'b0);
      check_ops("t3");
    end

    // backpressure on port 1 while port 0 waits
    drive_req(1, 16'h00FF, 16'h0F0F, NAND);
    wait_ready(1, "t4p1");
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    drive_req(0, 16'h0003, 16'h0004, ADD);
    #1;
    check("t4_p0_blocked_exec", req0_ready, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("t4_hold_valid", rsp1_valid, 1'b1);
      check("t4_hold_c", rsp1_c, 16'hFFF0);
      check("t4_p0_blocked_resp", req0_ready, 1'b0);
      check("t4_rsp0_quiet", rsp0_valid, 1'b0);
    end
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;
    exp_ops++;
    #1;
    check("t4_rsp1_dropped", rsp1_valid, 1'b0);
    check("t4_p0_now_ready", req0_ready, 1'b1);
    check_ops("t4");
    @(posedge clk);
    finish_rsp(0, 16'h0007, 1'b0, 0, "t4p0");

    // asynchronous reset in the middle of EXEC
    drive_req(0, 16'h1111, 16'h2222, ADD);
    wait_ready(0, "t5a");
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t5_exec_busy", busy, 1'b1);
    req1_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_req0_ready", req0_ready, 1'b0);
    check("t5_rst_req1_ready", req1_ready, 1'b0);
    check("t5_rst_rsp0_valid", rsp0_valid, 1'b0);
    exp_ops = 0;
    check_ops("t5_rst");
    @(negedge clk);
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("t5_no_rsp0", rsp0_valid, 1'b0);
      check("t5_not_busy", busy, 1'b0);
    end
    drive_req(0, 16'h0010, 16'h0001, SUB);
    drive_req(1, 16'h1000, 16'h0001, OR);
    #1;
    check("t5_req0_first", req0_ready, 1'b1);
    check("t5_req1_waits", req1_ready, 1'b0);
    @(posedge clk);
    finish_rsp(0, 16'h000F, 1'b0, 0, "t5p0");
    wait_ready(1, "t5p1");
    @(posedge clk);
    finish_rsp(1, 16'h1001, 1'b0, 0, "t5p1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
